sys_ctrl_regs: RTL and testbench
================================

// Module: sys_ctrl_regs
// PURPOSE
//  Processor control/status register file (PCS, IHA, IRA, IDN) with an integrated interrupt
//  controller. It sits beside the memory stage, services WSR/RSR, and captures NUM_IRQ device
//  lines. It hands fixed-priority interrupt requests to the pipeline with a req/ack handshake
//  and restores mode state on RETI.
// PARAMETERS
//  BITS          32     register/data width (>= 8)
//  NUM_IRQ       4      interrupt channels, 1..16; channel 0 = highest priority
//  IHA_RESET     0      reset value of IHA (handler address)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        synchronous, active-high
//  irq_i        in   NUM_IRQ  device request lines, level; rising edge latched as pending
//  wsr_en       in   1        WSR in memory stage this cycle
//  wsr_idx      in   2        0=PCS 1=IHA 2=IRA 3=IDN
//  wsr_data     in   BITS     value to write (RyVal)
//  rsr_idx      in   2        read select
//  rsr_data     out  BITS     combinational read of selected register
//  reti_i       in   1        RETI retiring this cycle
//  int_req_o    out  1        interrupt request to pipeline
//  int_ack_i    in   1        pipeline accepts interrupt, flushes, redirects to IHA
//  epc_i        in   BITS     PC to save, valid with int_ack_i
//  iha_o/ira_o  out  BITS     handler / return address
//  sys_mode_o   out  1        PCS.CM
//  priv_fault_o out  1        1-cycle pulse: WSR attempted with CM=0
// BEHAVIOUR
//  PCS bits: 0=IE 1=OIE 4=CM 5=OM; all other bits are read as 0 and ignore writes.
//  Reset: PCS=0x10 (CM=1, IE=0); IHA=IHA_RESET; IRA=0; IDN=0; pending=0; irq_q=0; state IDLE;
//   int_req_o=0; priv_fault_o=0. A reset during REQ aborts the request in the same cycle.
//  Pending: pend[i] <= 1 on irq_i[i] & ~irq_q[i]. It clears only when channel i is acked.
//   Capture continues while IE=0.
//  WSR: when wsr_en & CM, reg[wsr_idx] <= wsr_data (masked for PCS). When wsr_en & ~CM, no write
//   occurs and priv_fault_o=1 on the next cycle.
//  RSR: rsr_data shows the pre-write value; a write is visible the next cycle (no bypass).
//  FSM IDLE -> REQ: when IE & |pend & ~int_ack_i. The winning channel is latched into sel_q (lowest
//   set index). int_req_o=1 in REQ (registered). sel_q stays stable while in REQ, even if a
//   higher-priority channel arrives.
//  REQ -> IDLE on int_ack_i. Same edge: IRA<=epc_i; IDN<=sel_q (zero-extended); OIE<=IE;
//   IE<=0; OM<=CM; CM<=1; pend[sel_q]<=0.
//  REQ -> IDLE without ack if IE reads 0 (WSR cleared it); pending is kept.
//  Ack latency: the request is visible 1 cycle after the pending bit is set. The earliest ack is
//   in the same cycle int_req_o is first high.
//  RETI (state-independent): IE<=OIE; CM<=OM; OIE, OM unchanged.
//  Simultaneous events:
//   ack beats RETI; RETI is then ignored.
//   ack beats WSR to PCS/IRA/IDN; a WSR to IHA in the same cycle still applies.
//   RETI beats WSR to PCS.
//   An int_ack_i arriving in IDLE is ignored.
//  Re-entry: after RETI restores IE=1, any remaining pending bit raises a request 1 cycle later.
// STRUCTURE
//  Package sys_regs_pkg holds:
//   SR_PCS/SR_IHA/SR_IRA/SR_IDN index constants;
//   PCS_IE/PCS_OIE/PCS_CM/PCS_OM bit positions;
//   PCS_WMASK; PCS_RESET;
//   state enum {IDLE, REQ}.
//  Sub-module irq_priority_arbiter #(NUM_IRQ) holds edge capture, pending bits, clear-by-index,
//   and the fixed-priority encoder (any, idx). It is 1 instance; the register file and FSM live
//   in the top.
// TESTING
//  Reset, then RSR all four -> 0x10, IHA_RESET, 0, 0; int_req_o=0.
//  WSR IHA=0x400 with CM=1 -> reads 0x400. Clear CM, then WSR IRA=0x55 -> IRA unchanged,
//   priv_fault_o pulses once.
//  PCS IE=1; pulse irq_i[2] -> int_req_o next cycle. Ack with epc 0x1234 -> IRA=0x1234, IDN=2,
//   PCS=0x32 (CM=1, OM=1, OIE=1, IE=0).
//  irq_i[3] and irq_i[1] rise together with IE=1 -> IDN=1 first. RETI -> IE=1, second request
//   follows with IDN=3.
//  In REQ, WSR PCS IE=0 -> int_req_o drops, pend kept. Ack in IDLE is ignored; IRA unchanged.
//  Same cycle ack+RETI and ack+WSR(IHA=0x800) -> interrupt taken and IHA=0x800. Reset asserted
//   during REQ -> all reset values next cycle.

Source files
------------

// File: rtl/sys_regs_pkg.sv
// Shared constants for the processor control/status register file and its interrupt controller.
package sys_regs_pkg;
  localparam logic [1:0] SR_PCS = 2'd0;
  localparam logic [1:0] SR_IHA = 2'd1;
  localparam logic [1:0] SR_IRA = 2'd2;
  localparam logic [1:0] SR_IDN = 2'd3;

  localparam int PCS_IE  = 0;
  localparam int PCS_OIE = 1;
  localparam int PCS_CM  = 4;
  localparam int PCS_OM  = 5;

  localparam logic [7:0] PCS_WMASK = 8'h33;
  localparam logic [7:0] PCS_RESET = 8'h10;

  // Channel index width; covers up to 16 channels.
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/irq_priority_arbiter.sv
// Rising-edge capture of device lines into sticky pending bits, cleared per channel on
// acknowledge, with a fixed-priority encoder (lowest index wins).
module irq_priority_arbiter
  import sys_regs_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               clrEn,
  input  logic [IDX_W-1:0]   clrIdx,
  output logic               anyPend,
  output logic [IDX_W-1:0]   pendIdx
);
  logic [NUM_IRQ-1:0] irqQ;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] clrMask;

  always_comb begin
    clrMask = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (clrEn && clrIdx == IDX_W'(i)) clrMask[i] = 1'b1;
  end

  // A fresh edge on the channel being acked is kept as a new event.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqQ <= '0;
      pend <= '0;
    end else begin
      irqQ <= irq;
      pend <= (pend & ~clrMask) | (irq & ~irqQ);
    end
  end

  always_comb begin
    pendIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) pendIdx = IDX_W'(i);
  end

  assign anyPend = |pend;
endmodule

// File: rtl/sys_ctrl_regs.sv
// Control/status register file (PCS, IHA, IRA, IDN) with a req/ack interrupt handshake
// towards the pipeline and mode save/restore across interrupt entry and RETI.
module sys_ctrl_regs
  import sys_regs_pkg::*;
#(
  parameter int               BITS      = 32,
  parameter int               NUM_IRQ   = 4,
  parameter logic [BITS-1:0]  IHA_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               wsr_en,
  input  logic [1:0]         wsr_idx,
  input  logic [BITS-1:0]    wsr_data,
  input  logic [1:0]         rsr_idx,
  output logic [BITS-1:0]    rsr_data,
  input  logic               reti_i,
  output logic               int_req_o,
  input  logic               int_ack_i,
  input  logic [BITS-1:0]    epc_i,
  output logic [BITS-1:0]    iha_o,
  output logic [BITS-1:0]    ira_o,
  output logic               sys_mode_o,
  output logic               priv_fault_o
);
  logic [BITS-1:0]  pcs, iha, ira, idn;
  state_t           state;
  logic [IDX_W-1:0] selQ;
  logic             intReq, privFault;
  logic             anyPend;
  logic [IDX_W-1:0] pendIdx;
  logic             ie, cm, take, wsrOk;

  assign ie    = pcs[PCS_IE];
  assign cm    = pcs[PCS_CM];
  assign take  = (state == REQ) && int_ack_i;
  assign wsrOk = wsr_en && cm;

  irq_priority_arbiter #(.NUM_IRQ(NUM_IRQ)) uArb (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq_i),
    .clrEn   (take),
    .clrIdx  (selQ),
    .anyPend (anyPend),
    .pendIdx (pendIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcs       <= BITS'(PCS_RESET);
      iha       <= IHA_RESET;
      ira       <= '0;
      idn       <= '0;
      state     <= IDLE;
      selQ      <= '0;
      intReq    <= 1'b0;
      privFault <= 1'b0;
    end else begin
      privFault <= wsr_en && !cm;
      // IHA stays writable even on the acknowledge edge.
      if (wsrOk && wsr_idx == SR_IHA) iha <= wsr_data;
      if (take) begin
        ira          <= epc_i;
        idn          <= BITS'(selQ);
        pcs[PCS_OIE] <= ie;
        pcs[PCS_IE]  <= 1'b0;
        pcs[PCS_OM]  <= cm;
        pcs[PCS_CM]  <= 1'b1;
      end else begin
        if (wsrOk && wsr_idx == SR_IRA) ira <= wsr_data;
        if (wsrOk && wsr_idx == SR_IDN) idn <= wsr_data;
        if (reti_i) begin
          pcs[PCS_IE] <= pcs[PCS_OIE];
          pcs[PCS_CM] <= pcs[PCS_OM];
        end else if (wsrOk && wsr_idx == SR_PCS) begin
          pcs <= wsr_data & BITS'(PCS_WMASK);
        end
      end
      case (state)
        IDLE: if (ie && anyPend && !int_ack_i) begin
          state  <= REQ;
          selQ   <= pendIdx;
          intReq <= 1'b1;
        end
        REQ: if (int_ack_i || !ie) begin
          state  <= IDLE;
          intReq <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          intReq <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (rsr_idx)
      SR_PCS:  rsr_data = pcs;
      SR_IHA:  rsr_data = iha;
      SR_IRA:  rsr_data = ira;
      default: rsr_data = idn;
    endcase
  end

  assign int_req_o    = intReq;
  assign priv_fault_o = privFault;
  assign iha_o        = iha;
  assign ira_o        = ira;
  assign sys_mode_o   = cm;
endmodule

// File: tb/tb_sys_ctrl_regs.sv
// Directed bench for sys_ctrl_regs: register access, privilege, interrupt entry/exit and races.
module tb_sys_ctrl_regs;
  import sys_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_i = '0;
  logic        wsr_en = 1'b0;
  logic [1:0]  wsr_idx = '0;
  logic [31:0] wsr_data = '0;
  logic [1:0]  rsr_idx = '0;
  logic [31:0] rsr_data;
  logic        reti_i = 1'b0;
  logic        int_req_o;
  logic        int_ack_i = 1'b0;
  logic [31:0] epc_i = '0;
  logic [31:0] iha_o, ira_o;
  logic        sys_mode_o, priv_fault_o;

  int total = 0;
  int bad = 0;
  logic [31:0] v;

  sys_ctrl_regs #(.BITS(32), .NUM_IRQ(4), .IHA_RESET(32'h100)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .wsr_en(wsr_en), .wsr_idx(wsr_idx),
    .wsr_data(wsr_data), .rsr_idx(rsr_idx), .rsr_data(rsr_data), .reti_i(reti_i),
    .int_req_o(int_req_o), .int_ack_i(int_ack_i), .epc_i(epc_i), .iha_o(iha_o),
    .ira_o(ira_o), .sys_mode_o(sys_mode_o), .priv_fault_o(priv_fault_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wsr(input logic [1:0] idx, input logic [31:0] data);
    wsr_en = 1'b1; wsr_idx = idx; wsr_data = data;
    tick();
    wsr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    rsr_idx = idx;
    #1;
    d = rsr_data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(SR_PCS, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL reset_pcs got=%h exp=%h", v, 32'h10); end
    rd(SR_IHA, v); total++; if (v !== 32'h100) begin bad++; $display("FAIL reset_iha got=%h exp=%h", v, 32'h100); end
    rd(SR_IRA, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_ira got=%h exp=0", v); end
    rd(SR_IDN, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_idn got=%h exp=0", v); end
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", int_req_o); end
    total++; if (sys_mode_o !== 1'b1 || priv_fault_o !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b/%b exp=1/0", sys_mode_o, priv_fault_o); end
  endtask

  task automatic test_wsr_priv();
    wsr(SR_IHA, 32'h400);
    rd(SR_IHA, v); total++; if (v !== 32'h400) begin bad++; $display("FAIL wsr_iha got=%h exp=%h", v, 32'h400); end
    // Read during the write cycle must still show the old value.
    wsr_en = 1'b1; wsr_idx = SR_IRA; wsr_data = 32'h77;
    rd(SR_IRA, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rsr_nobypass got=%h exp=0", v); end
    tick(); wsr_en = 1'b0;
    rd(SR_IRA, v); total++; if (v !== 32'h77) begin bad++; $display("FAIL wsr_ira got=%h exp=%h", v, 32'h77); end
    wsr(SR_PCS, 32'hFFFF_FFFF);
    rd(SR_PCS, v); total++; if (v !== 32'h33) begin bad++; $display("FAIL pcs_mask got=%h exp=%h", v, 32'h33); end
    wsr(SR_PCS, 32'h0);
    total++; if (sys_mode_o !== 1'b0) begin bad++; $display("FAIL cm_clear got=%b exp=0", sys_mode_o); end
    wsr(SR_IRA, 32'h55);
    total++; if (priv_fault_o !== 1'b1) begin bad++; $display("FAIL priv_pulse got=%b exp=1", priv_fault_o); end
    tick();
    total++; if (priv_fault_o !== 1'b0) begin bad++; $display("FAIL priv_single got=%b exp=0", priv_fault_o); end
    rd(SR_IRA, v); total++; if (v !== 32'h77) begin bad++; $display("FAIL priv_nowrite got=%h exp=%h", v, 32'h77); end
  endtask

  task automatic test_irq_basic();
    do_reset();
    wsr(SR_PCS, 32'h11);
    irq_i = 4'b0100;
    tick();
    irq_i = 4'b0000;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL req_early got=%b exp=0", int_req_o); end
    tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL req_raise got=%b exp=1", int_req_o); end
    int_ack_i = 1'b1; epc_i = 32'h1234;
    tick();
    int_ack_i = 1'b0;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL req_after_ack got=%b exp=0", int_req_o); end
    rd(SR_IRA, v); total++; if (v !== 32'h1234) begin bad++; $display("FAIL ack_ira got=%h exp=%h", v, 32'h1234); end
    rd(SR_IDN, v); total++; if (v !== 32'h2) begin bad++; $display("FAIL ack_idn got=%h exp=2", v); end
    rd(SR_PCS, v); total++; if (v !== 32'h32) begin bad++; $display("FAIL ack_pcs got=%h exp=%h", v, 32'h32); end
    reti_i = 1'b1;
    tick();
    reti_i = 1'b0;
    rd(SR_PCS, v); total++; if (v !== 32'h33) begin bad++; $display("FAIL reti_pcs got=%h exp=%h", v, 32'h33); end
    tick(); tick();
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL pend_cleared got=%b exp=0", int_req_o); end
  endtask

  task automatic test_priority();
    irq_i = 4'b1010;
    tick(); tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL prio_req got=%b exp=1", int_req_o); end
    int_ack_i = 1'b1; epc_i = 32'h2000;
    tick();
    int_ack_i = 1'b0;
    rd(SR_IDN, v); total++; if (v !== 32'h1) begin bad++; $display("FAIL prio_first got=%h exp=1", v); end
    reti_i = 1'b1;
    tick();
    reti_i = 1'b0;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL reentry_wait got=%b exp=0", int_req_o); end
    tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL reentry_req got=%b exp=1", int_req_o); end
    int_ack_i = 1'b1; epc_i = 32'h3000;
    tick();
    int_ack_i = 1'b0; irq_i = 4'b0000;
    rd(SR_IDN, v); total++; if (v !== 32'h3) begin bad++; $display("FAIL prio_second got=%h exp=3", v); end
    reti_i = 1'b1;
    tick();
    reti_i = 1'b0;
  endtask

  task automatic test_ie_drop();
    irq_i = 4'b0001;
    tick();
    irq_i = 4'b0000;
    tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL drop_req got=%b exp=1", int_req_o); end
    wsr(SR_PCS, 32'h30);
    tick();
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL drop_ie got=%b exp=0", int_req_o); end
    int_ack_i = 1'b1; epc_i = 32'h9999;
    tick();
    int_ack_i = 1'b0;
    rd(SR_IRA, v); total++; if (v !== 32'h3000) begin bad++; $display("FAIL idle_ack_ira got=%h exp=%h", v, 32'h3000); end
    rd(SR_PCS, v); total++; if (v !== 32'h30) begin bad++; $display("FAIL idle_ack_pcs got=%h exp=%h", v, 32'h30); end
    wsr(SR_PCS, 32'h31);
    tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL pend_kept got=%b exp=1", int_req_o); end
  endtask

  task automatic test_back_to_back();
    int_ack_i = 1'b1; epc_i = 32'h4444; reti_i = 1'b1;
    wsr_en = 1'b1; wsr_idx = SR_IHA; wsr_data = 32'h800;
    tick();
    int_ack_i = 1'b0; reti_i = 1'b0; wsr_en = 1'b0;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL race_req got=%b exp=0", int_req_o); end
    rd(SR_IRA, v); total++; if (v !== 32'h4444) begin bad++; $display("FAIL race_ira got=%h exp=%h", v, 32'h4444); end
    rd(SR_IDN, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL race_idn got=%h exp=0", v); end
    rd(SR_PCS, v); total++; if (v !== 32'h32) begin bad++; $display("FAIL race_pcs got=%h exp=%h", v, 32'h32); end
    total++; if (iha_o !== 32'h800) begin bad++; $display("FAIL race_iha got=%h exp=%h", iha_o, 32'h800); end
    // RETI wins over a PCS write in the same cycle.
    reti_i = 1'b1;
    wsr_en = 1'b1; wsr_idx = SR_PCS; wsr_data = 32'h10;
    tick();
    reti_i = 1'b0; wsr_en = 1'b0;
    rd(SR_PCS, v); total++; if (v !== 32'h33) begin bad++; $display("FAIL reti_vs_wsr got=%h exp=%h", v, 32'h33); end
  endtask

  task automatic test_reset_in_req();
    irq_i = 4'b0010;
    tick();
    irq_i = 4'b0000;
    tick();
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL rst_req_pre got=%b exp=1", int_req_o); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", int_req_o); end
    rd(SR_PCS, v); total++; if (v !== 32'h10) begin bad++; $display("FAIL rst_pcs got=%h exp=%h", v, 32'h10); end
    rd(SR_IHA, v); total++; if (v !== 32'h100) begin bad++; $display("FAIL rst_iha got=%h exp=%h", v, 32'h100); end
    rd(SR_IRA, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_ira got=%h exp=0", v); end
    wsr(SR_PCS, 32'h11);
    tick(); tick();
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b exp=0", int_req_o); end
  endtask

  initial begin
    test_reset();
    test_wsr_priv();
    test_irq_basic();
    test_priority();
    test_ie_drop();
    test_back_to_back();
    test_reset_in_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
